// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: default bus widths
//   matching the CPU memory, the arbiter state encoding and the read-return
//   requester tags.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  // IDLE: bus shared between CPU and debug; LOCK: debug owns the bus.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Which requester the read data returning next cycle belongs to.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_DBG  = 2'd2;

endpackage

// File: rtl/mem_arb_rdmux.sv
// mem_arb_rdmux
//   Read-return stage of the memory port arbiter. Remembers which requester
//   issued the read in the previous cycle, raises that requester's rvalid
//   while the memory presents the data, and holds each requester's last read
//   data until its next rvalid.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cpu_rd, dbg_rd          read granted to CPU / debug this cycle
//   mem_rdata               memory read data (valid the cycle after the read)
//   cpu_rvalid, cpu_rdata   CPU read response
//   dbg_rvalid, dbg_rdata   debug read response
module mem_arb_rdmux
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              dbg_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [1:0]        rd_tag;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dbg_hold;

  // The tag is rewritten every cycle so back-to-back reads from alternating
  // requesters each land on the right port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag <= TAG_NONE;
    end else if (cpu_rd) begin
      rd_tag <= TAG_CPU;
    end else if (dbg_rd) begin
      rd_tag <= TAG_DBG;
    end else begin
      rd_tag <= TAG_NONE;
    end
  end

  // Gating with reset drops a read that was in flight when reset hit.
  assign cpu_rvalid = (rd_tag == TAG_CPU) && !reset;
  assign dbg_rvalid = (rd_tag == TAG_DBG) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold <= '0;
      dbg_hold <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold <= mem_rdata;
      if (dbg_rvalid) dbg_hold <= mem_rdata;
    end
  end

  // Memory data passes straight through in the rvalid cycle, then the
  // captured copy takes over.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_hold;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port memory between the CPU controller and the
//   debug/loader port. At most one access is issued per cycle; grants and
//   memory strobes are combinational from the current state and requests.
//   CPU has fixed priority, but debug is forced through after MAX_WAIT
//   consecutive denied cycles. A debug grant with dbg_lock=1 moves the
//   arbiter into LOCK, where only debug is served until dbg_lock drops.
//
//   Build option ARB_ROUND_ROBIN_EN: contention in IDLE is resolved by a
//   1-bit last-winner pointer instead (the previous contended loser wins;
//   CPU favoured out of reset). MAX_WAIT is then unused.
//
// Ports:
//   clk, reset                                  clock, sync active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt            CPU request bundle and grant
//   cpu_rvalid, cpu_rdata                       CPU read response
//   dbg_req/we/addr/wdata, dbg_lock -> dbg_gnt  debug request bundle, grant
//   dbg_rvalid, dbg_rdata                       debug read response
//   mem_en/we/addr/wdata, mem_rdata             memory array interface
//   dbg_owns                                    high while in LOCK
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_owns
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       cpu_win;
  logic       dbg_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic favour_dbg;
  logic favour_dbg_nxt;
`else
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Winner selection and next state. Nothing is granted in a reset cycle.
  always_comb begin
    cpu_win   = 1'b0;
    dbg_win   = 1'b0;
    state_nxt = state;
`ifdef ARB_ROUND_ROBIN_EN
    favour_dbg_nxt = favour_dbg;
`endif
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cpu_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            dbg_win        = favour_dbg;
            cpu_win        = !favour_dbg;
            favour_dbg_nxt = !favour_dbg;
`else
            dbg_win = (wait_cnt == WAIT_LIMIT);
            cpu_win = !dbg_win;
`endif
          end else begin
            cpu_win = cpu_req;
            dbg_win = dbg_req;
          end
          if (dbg_win && dbg_lock) state_nxt = LOCK;
        end
        LOCK: begin
          // Debug may still use the cycle in which it releases the lock.
          dbg_win = dbg_req;
          if (!dbg_lock) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      favour_dbg <= 1'b0;
    end else begin
      favour_dbg <= favour_dbg_nxt;
    end
  end
`else
  // Counts consecutive cycles debug asked and lost; it cannot pass
  // WAIT_LIMIT because debug wins outright once the limit is reached.
  always_comb begin
    wait_cnt_nxt = '0;
    if (dbg_req && !dbg_win) begin
      wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
    end
  end
`endif

  assign cpu_gnt   = cpu_win;
  assign dbg_gnt   = dbg_win;
  assign dbg_owns  = (state == LOCK) && !reset;

  assign mem_en    = cpu_win || dbg_win;
  assign mem_we    = cpu_win ? cpu_we    : (dbg_win ? dbg_we    : 1'b0);
  assign mem_addr  = cpu_win ? cpu_addr  : (dbg_win ? dbg_addr  : '0);
  assign mem_wdata = cpu_win ? cpu_wdata : (dbg_win ? dbg_wdata : '0);

  mem_arb_rdmux #(
    .DATA_W (DATA_W)
  ) u_rdmux (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_win && !cpu_we),
    .dbg_rd     (dbg_win && !dbg_we),
    .mem_rdata  (mem_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural synchronous
//   memory. Grants and strobes are checked in the cycle they are issued;
//   read responses go through a scoreboard queue popped by a monitor.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req, dbg_we, dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              dbg_owns;

  logic [DATA_W-1:0] tb_mem [2**ADDR_W];

  typedef struct {
    bit                is_cpu;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t exp_q [$];
  int      checks   = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_owns   (dbg_owns)
  );

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkGrant(input string tag, input logic cg, input logic dg,
                            input logic [ADDR_W-1:0] addr);
    checkOutput({tag, "_cpu_gnt"},  32'(cpu_gnt),  32'(cg));
    checkOutput({tag, "_dbg_gnt"},  32'(dbg_gnt),  32'(dg));
    checkOutput({tag, "_mem_en"},   32'(mem_en),   32'(cg | dg));
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic applyStimulus(input logic c_req, input logic c_we,
                               input logic [ADDR_W-1:0] c_addr,
                               input logic [DATA_W-1:0] c_wdata,
                               input logic d_req, input logic d_we,
                               input logic [ADDR_W-1:0] d_addr,
                               input logic [DATA_W-1:0] d_wdata,
                               input logic d_lock);
    @(posedge clk);
    #1;
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    dbg_req   = d_req;
    dbg_we    = d_we;
    dbg_addr  = d_addr;
    dbg_wdata = d_wdata;
    dbg_lock  = d_lock;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic expectRead(input bit is_cpu, input logic [DATA_W-1:0] data);
    rd_exp_t e;
    e.is_cpu = is_cpu;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Monitor: mutual exclusion of grants every cycle, and each read response
  // against the head of the scoreboard.
  always @(negedge clk) begin
    rd_exp_t e;
    checkOutput("gnt_exclusive", 32'(cpu_gnt & dbg_gnt), 0);
    if (cpu_rvalid || dbg_rvalid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rvalid", {30'd0, dbg_rvalid, cpu_rvalid}, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rvalid_cpu", 32'(cpu_rvalid), 32'(e.is_cpu));
        checkOutput("rvalid_dbg", 32'(dbg_rvalid), 32'(!e.is_cpu));
        checkOutput("rdata", e.is_cpu ? 32'(cpu_rdata) : 32'(dbg_rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] dbg_pattern;
    logic       dwin;

    for (int i = 0; i < 2**ADDR_W; i++) tb_mem[i] = '0;
    tb_mem[1] = 8'h10;
    tb_mem[2] = 8'h20;
    tb_mem[3] = 8'hA5;

    reset     = 1'b1;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req   = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_lock  = 1'b0;

    // Requests during reset are ignored.
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    @(negedge clk);
    checkGrant("in_reset", 1'b0, 1'b0, '0);
    checkOutput("in_reset_owns", 32'(dbg_owns), 0);
    checkOutput("in_reset_mem_we", 32'(mem_we), 0);

    @(posedge clk);
    #1;
    reset   = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_cpu_rdata", 32'(cpu_rdata), 0);
    checkOutput("post_reset_dbg_rdata", 32'(dbg_rdata), 0);
    checkOutput("post_reset_cpu_rvalid", 32'(cpu_rvalid), 0);

    // Solo CPU read of address 3.
    applyStimulus(1'b1, 1'b0, 5'h03, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkGrant("solo_rd", 1'b1, 1'b0, 5'h03);
    checkOutput("solo_rd_mem_we", 32'(mem_we), 0);
    expectRead(1'b1, 8'hA5);
    idleCycle();
    @(negedge clk);
    checkOutput("solo_rd_cpu_rvalid", 32'(cpu_rvalid), 1);
    checkOutput("solo_rd_dbg_rvalid", 32'(dbg_rvalid), 0);
    idleCycle();
    @(negedge clk);
    checkOutput("solo_rd_rvalid_once", 32'(cpu_rvalid), 0);
    checkOutput("solo_rd_rdata_hold", 32'(cpu_rdata), 'hA5);

    // Pipelined reads from alternating requesters.
    applyStimulus(1'b1, 1'b0, 5'h01, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkGrant("pipe_cpu", 1'b1, 1'b0, 5'h01);
    expectRead(1'b1, 8'h10);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'h02, '0, 1'b0);
    @(negedge clk);
    checkGrant("pipe_dbg", 1'b0, 1'b1, 5'h02);
    expectRead(1'b0, 8'h20);
    idleCycle();
    @(negedge clk);
    checkOutput("pipe_cpu_rdata_hold", 32'(cpu_rdata), 'h10);

    // Continuous contention, both writing.
`ifdef ARB_ROUND_ROBIN_EN
    dbg_pattern = 10'b10_1010_1010;
`else
    dbg_pattern = 10'b10_0001_0000;
`endif
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 5'h08, 8'hC0, 1'b1, 1'b1, 5'h09, 8'hD0, 1'b0);
      @(negedge clk);
      dwin = dbg_pattern[i];
      checkGrant($sformatf("contend%0d", i), !dwin, dwin, dwin ? 5'h09 : 5'h08);
      checkOutput($sformatf("contend%0d_wdata", i), 32'(mem_wdata),
                  dwin ? 32'h0D0 : 32'h0C0);
    end
    idleCycle();
    @(negedge clk);

    // Debug lock burst writing 11/22/33 to addresses 0..2.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'h00, 8'h11, 1'b1);
    @(negedge clk);
    checkGrant("lock0", 1'b0, 1'b1, 5'h00);
    checkOutput("lock0_owns", 32'(dbg_owns), 0);
    applyStimulus(1'b1, 1'b0, 5'h03, '0, 1'b1, 1'b1, 5'h01, 8'h22, 1'b1);
    @(negedge clk);
    checkGrant("lock1", 1'b0, 1'b1, 5'h01);
    checkOutput("lock1_owns", 32'(dbg_owns), 1);
    applyStimulus(1'b1, 1'b0, 5'h03, '0, 1'b1, 1'b1, 5'h02, 8'h33, 1'b1);
    @(negedge clk);
    checkGrant("lock2", 1'b0, 1'b1, 5'h02);
    checkOutput("lock2_owns", 32'(dbg_owns), 1);
    applyStimulus(1'b1, 1'b0, 5'h03, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkGrant("lock_release", 1'b0, 1'b0, '0);
    checkOutput("lock_release_owns", 32'(dbg_owns), 1);
    applyStimulus(1'b1, 1'b0, 5'h03, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkGrant("post_lock_cpu", 1'b1, 1'b0, 5'h03);
    checkOutput("post_lock_owns", 32'(dbg_owns), 0);
    expectRead(1'b1, 8'hA5);
    idleCycle();
    @(negedge clk);
    checkOutput("burst_mem0", 32'(tb_mem[0]), 'h11);
    checkOutput("burst_mem1", 32'(tb_mem[1]), 'h22);
    checkOutput("burst_mem2", 32'(tb_mem[2]), 'h33);

    // Reset while locked with a debug read in flight.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'h01, '0, 1'b1);
    @(negedge clk);
    checkGrant("rl_rd", 1'b0, 1'b1, 5'h01);
    expectRead(1'b0, 8'h22);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'h00, '0, 1'b1);
    @(negedge clk);
    checkGrant("rl_pending", 1'b0, 1'b1, 5'h00);
    checkOutput("rl_pending_owns", 32'(dbg_owns), 1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
    dbg_req  = 1'b0;
    dbg_lock = 1'b1;
    @(negedge clk);
    checkGrant("rl_reset", 1'b0, 1'b0, '0);
    checkOutput("rl_reset_owns", 32'(dbg_owns), 0);
    checkOutput("rl_reset_dbg_rvalid", 32'(dbg_rvalid), 0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    dbg_lock  = 1'b0;
    cpu_req   = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h0A; cpu_wdata = 8'h5A;
    @(negedge clk);
    checkGrant("rl_after", 1'b1, 1'b0, 5'h0A);
    checkOutput("rl_after_owns", 32'(dbg_owns), 0);
    checkOutput("rl_after_dbg_rvalid", 32'(dbg_rvalid), 0);
    checkOutput("rl_after_dbg_rdata", 32'(dbg_rdata), 0);
    checkOutput("rl_after_cpu_rdata", 32'(cpu_rdata), 0);
    idleCycle();
    repeat (2) @(negedge clk);
    checkOutput("rl_write_mem10", 32'(tb_mem[10]), 'h5A);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: the CPU controller (fetch, LDM/STM cycles) and an external debug/loader port (program load, memory inspect).
- Sits between the controller/datapath memory-address path and the memory array.
- Issues at most one memory access per cycle; steers returned read data to the granted requester.
- Provides fixed CPU priority with starvation protection for debug, plus a debug bus-lock mode for burst program loading.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 8, memory data width.
- MAX_WAIT, 4, number of consecutive cycles debug may be denied before it is forced to win. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  CPU write enable (qualifies cpu_req)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request bundle, same rules as the CPU bundle
- dbg_lock  in  1  keep the bus after the next debug grant
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug response bundle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0
- dbg_owns  out  1  high while in the LOCK state (the controller stalls on it)

Behaviour:
- Reset: state=IDLE; wait_cnt=0; rd_tag=none; all gnt/rvalid/mem_en/mem_we/dbg_owns = 0; rdata/mem_addr/mem_wdata = 0.
- Grants are combinational from the current state and requests. mem_en/mem_we/mem_addr/mem_wdata are driven combinationally from the winner in the same cycle as the gnt (zero latency).
- Requesters must hold req/we/addr/wdata stable until gnt. A gnt consumes exactly one access.
- Reads: rvalid is registered, asserted exactly 1 cycle after the granted read. rdata = mem_rdata in that cycle, held until the next rvalid for that requester. Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. The read tag is registered each cycle, so pipelined reads from alternating requesters return in order.
- State IDLE (shared):
  - Only one requester active: it wins.
  - Both requesting: CPU wins unless wait_cnt == MAX_WAIT, in which case debug wins.
  - wait_cnt increments (saturating) each cycle debug requests but loses, and clears on any debug grant or when dbg_req is low.
  - A debug grant with dbg_lock=1 moves the FSM to LOCK.
- State LOCK:
  - Only debug is granted; cpu_gnt=0 regardless of cpu_req.
  - dbg_owns=1.
  - Returns to IDLE on the first cycle dbg_lock=0. The transition is registered; in that cycle debug may still be granted if requesting.
- cpu_gnt and dbg_gnt are never both 1.
- reset takes priority over everything, including mid-lock or a pending read: the pending rvalid is dropped (not delivered).
- Requests arriving during reset are ignored; no grant is issued in the reset cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: in IDLE, contention is resolved by a 1-bit last-winner pointer (the loser of the previous contended cycle wins next). wait_cnt and MAX_WAIT are unused, but the parameter remains. Pointer reset value = CPU favoured.
- Undefined: fixed CPU priority with MAX_WAIT starvation escape, as specified above.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding localparams: IDLE=1'b0, LOCK=1'b1.
  - Requester tag constants: TAG_NONE=2'd0, TAG_CPU=2'd1, TAG_DBG=2'd2.
  - Default ADDR_W/DATA_W consistent with the CPU memory.
- Sub-module mem_arb_rdmux: registered read-return stage (tag register, rvalid generation, per-requester rdata hold). Everything else stays in the top module.

Test Plan:
- Solo CPU read: cpu_req=1, we=0, addr=5'h03, memory[3]=8'hA5 -> cpu_gnt same cycle, mem_en=1, mem_addr=3; next cycle cpu_rvalid=1, cpu_rdata=8'hA5; dbg_rvalid stays 0.
- Contention with starvation (MAX_WAIT=4): both request continuously -> cpu_gnt for 4 cycles, dbg_gnt on the 5th, then CPU again; never both grants high.
- Debug lock burst: dbg_req=1, dbg_lock=1, writes 8'h11/22/33 to addr 0..2 while cpu_req=1 -> dbg_owns=1, cpu_gnt=0 throughout; memory holds the values; after dbg_lock=0, CPU is granted within 2 cycles.
- Pipelined mixed reads: CPU read addr 1 (8'h10), then debug read addr 2 (8'h20) on consecutive cycles -> cpu_rvalid/8'h10, then dbg_rvalid/8'h20 on successive cycles.
- Reset mid-operation: assert reset in LOCK with a debug read pending -> the next cycle shows dbg_owns=0, dbg_rvalid=0, all outputs zero; after release, a CPU request is granted immediately.
- ARB_ROUND_ROBIN_EN defined, both requesting continuously -> grants alternate CPU, DBG, CPU, DBG starting with CPU.
